// File: rtl/ext_bus_demux.sv
// Slave-side demultiplexer for the MCU external bus: two-phase address capture, region decode,
// and one byte access per address phase. Define EXTBUS_TIMEOUT_EN to bound the wait for mem_ready.
module ext_bus_demux #(
  parameter logic [11:0] IO_TAG         = 12'h1A1,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  TO_DATA        = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ext_ad_in,
  output logic [7:0]  ext_ad_out,
  output logic        ext_ad_oe,
  input  logic        ae,
  input  logic        ext_read,
  input  logic        ext_write,
  output logic        ext_ready,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_sel_io,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_DONE, S_CMD, S_ACCESS, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        sel_io_q, sel_io_d;
  logic        rd_acc_q, rd_acc_d;
  logic        wdrawn_q, wdrawn_d;
  logic        is_io, is_off, strobe_on;

`ifdef EXTBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic [8:0] unused_cfg;
  assign unused_cfg = {TO_DATA, ^TIMEOUT_CYCLES};
`endif

  assign is_io     = (addr_q[31:20] == IO_TAG) && (addr_q[19:17] == 3'b000);
  assign is_off    = (|addr_q[31:12]) && !is_io;
  assign strobe_on = rd_acc_q ? ext_read : ext_write;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bus_err_d = bus_err_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    sel_io_d  = sel_io_q;
    rd_acc_d  = rd_acc_q;
    wdrawn_d  = wdrawn_q;
`ifdef EXTBUS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ae) begin
          addr_d[15:0] = ext_ad_in;
          state_d      = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (ae) begin
          addr_d[31:16] = ext_ad_in;
          state_d       = S_ADDR_DONE;
        end else begin
          bus_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ADDR_DONE: begin
        if (ae) begin
          addr_d[15:0] = ext_ad_in;
          state_d      = S_ADDR_HI;
        end else begin
          wdata_d = ext_ad_in[7:0];
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (ae) begin
          addr_d[15:0] = ext_ad_in;
          state_d      = S_ADDR_HI;
        end else if (ext_read && ext_write) begin
          bus_err_d = 1'b1;
        end else if ((ext_read || ext_write) && (is_io || is_off)) begin
          mem_rd_d = ext_read;
          mem_wr_d = ext_write;
          sel_io_d = is_io;
          rd_acc_d = ext_read;
          wdrawn_d = 1'b0;
`ifdef EXTBUS_TIMEOUT_EN
          cnt_d    = '0;
`endif
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A withdrawn strobe still waits out the target so its handshake completes cleanly.
        if (!strobe_on) wdrawn_d = 1'b1;
        if (mem_ready) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (rd_acc_q) rdata_d = mem_rdata;
          state_d = (wdrawn_q || !strobe_on) ? S_IDLE : S_RESP;
`ifdef EXTBUS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          bus_err_d = 1'b1;
          if (rd_acc_q) rdata_d = TO_DATA;
          state_d = (wdrawn_q || !strobe_on) ? S_IDLE : S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      S_RESP: begin
        if (!ext_read && !ext_write) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      sel_io_q  <= 1'b0;
      rd_acc_q  <= 1'b0;
      wdrawn_q  <= 1'b0;
`ifdef EXTBUS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      sel_io_q  <= sel_io_d;
      rd_acc_q  <= rd_acc_d;
      wdrawn_q  <= wdrawn_d;
`ifdef EXTBUS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign ext_ready  = (state_q == S_RESP);
  assign ext_ad_oe  = (state_q == S_RESP) && rd_acc_q;
  assign ext_ad_out = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_sel_io = sel_io_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_ext_bus_demux.sv
// Bench for ext_bus_demux: directed bus scenarios plus randomized transactions checked
// against expectations derived from the address-decode and handshake rules.
module tb_ext_bus_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ext_ad_in;
  logic [7:0]  ext_ad_out;
  logic        ext_ad_oe, ae, ext_read, ext_write, ext_ready;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_sel_io, mem_ready, bus_err;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ext_bus_demux #(.IO_TAG(12'h1A1), .TIMEOUT_CYCLES(16), .TO_DATA(8'hFF)) dut (
    .clk(clk), .rst(rst), .ext_ad_in(ext_ad_in), .ext_ad_out(ext_ad_out),
    .ext_ad_oe(ext_ad_oe), .ae(ae), .ext_read(ext_read), .ext_write(ext_write),
    .ext_ready(ext_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_sel_io(mem_sel_io), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit ref_io(input logic [31:0] a);
    return (a[31:20] == 12'h1A1) && (a[19:17] == 3'b000);
  endfunction

  function automatic bit ref_off(input logic [31:0] a);
    return (a[31:12] != 20'h0) && !ref_io(a);
  endfunction

  task automatic do_reset();
    ae = 0; ext_read = 0; ext_write = 0; mem_ready = 0;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc();
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [7:0] wd);
    ae = 1; ext_ad_in = a[15:0];
    cyc();
    ext_ad_in = a[31:16];
    cyc();
    ae = 0; ext_ad_in = {8'($urandom), wd};
    cyc();
  endtask

  // One complete MCU access; the target answers dly cycles after it sees the request.
  task automatic xfer(input string tag, input logic [31:0] a, input logic [7:0] wd,
                      input bit rd, input int dly, input logic [7:0] rdat);
    bit io, off;
    io  = ref_io(a);
    off = ref_off(a);
    addr_phase(a, wd);
    chk({tag, ":addr"}, mem_addr, a);
    chk({tag, ":wdata"}, {24'h0, mem_wdata}, {24'h0, wd});
    if (rd) ext_read = 1; else ext_write = 1;
    cyc();
    if (io || off) begin
      chk({tag, ":rd"}, {31'h0, mem_rd}, {31'h0, rd});
      chk({tag, ":wr"}, {31'h0, mem_wr}, {31'h0, !rd});
      chk({tag, ":sel"}, {31'h0, mem_sel_io}, {31'h0, io});
      for (int i = 0; i < dly; i++) begin
        cyc();
        chk({tag, ":hold"}, {30'h0, mem_rd | mem_wr, ext_ready}, 32'h2);
      end
      mem_ready = 1; mem_rdata = rdat;
      cyc();
      mem_ready = 0; mem_rdata = 8'($urandom);
      chk({tag, ":ready"}, {31'h0, ext_ready}, 32'h1);
      chk({tag, ":oe"}, {31'h0, ext_ad_oe}, {31'h0, rd});
      if (rd) chk({tag, ":rdata"}, {24'h0, ext_ad_out}, {24'h0, rdat});
      chk({tag, ":drop"}, {30'h0, mem_rd, mem_wr}, 32'h0);
      chk({tag, ":addr_hold"}, mem_addr, a);
      ext_read = 0; ext_write = 0;
      cyc();
      chk({tag, ":ready_off"}, {30'h0, ext_ready, ext_ad_oe}, 32'h0);
    end else begin
      cyc(3);
      chk({tag, ":onchip"}, {29'h0, mem_rd, mem_wr, ext_ready}, 32'h0);
      ext_read = 0; ext_write = 0;
    end
  endtask

  initial begin
    bit seen;
    logic [31:0] a;
    ext_ad_in = '0; mem_rdata = '0;
    ae = 0; ext_read = 0; ext_write = 0; mem_ready = 0;
    rst = 1'b0;
    #1;
    chk("rst_ctl", {25'h0, ext_ad_oe, ext_ready, mem_rd, mem_wr, mem_sel_io, bus_err, 1'b0}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data", {16'h0, mem_wdata, ext_ad_out}, 32'h0);
    cyc(2);
    rst = 1'b1;
    cyc();

    xfer("t1_onchip", 32'h0000_0010, 8'h5A, 1'b0, 2, 8'h00);
    xfer("t1_off", 32'h0002_0010, 8'h5A, 1'b0, 1, 8'h00);
    xfer("t2_io", 32'h1A10_0004, 8'h00, 1'b1, 5, 8'hC3);
    xfer("t3_notio", 32'h1A12_0000, 8'h00, 1'b1, 0, 8'h3C);
    chk("no_err", {31'h0, bus_err}, 32'h0);

    // Short AE phase.
    do_reset();
    ae = 1; ext_ad_in = 16'h1234;
    cyc();
    ae = 0;
    cyc();
    chk("short_ae_err", {31'h0, bus_err}, 32'h1);
    chk("short_ae_nostb", {30'h0, mem_rd, mem_wr}, 32'h0);

    // Both strobes together.
    do_reset();
    addr_phase(32'h0005_0000, 8'h11);
    ext_read = 1; ext_write = 1;
    cyc();
    chk("both_err", {31'h0, bus_err}, 32'h1);
    chk("both_nostb", {30'h0, mem_rd, mem_wr}, 32'h0);

    // Reset during ACCESS.
    do_reset();
    addr_phase(32'h1A10_0100, 8'h00);
    ext_read = 1;
    cyc();
    chk("pre_rst_rd", {31'h0, mem_rd}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {29'h0, mem_rd, ext_ready, bus_err}, 32'h0);
    ext_read = 0;
    cyc();
    rst = 1'b1;
    cyc();
    xfer("after_rst", 32'h0100_0000, 8'hA5, 1'b1, 3, 8'h77);

    // Strobe withdrawn during ACCESS: finish target handshake, no ready.
    addr_phase(32'h0003_0000, 8'h42);
    ext_write = 1;
    cyc();
    ext_write = 0;
    cyc(2);
    chk("wd_hold", {31'h0, mem_wr}, 32'h1);
    mem_ready = 1;
    cyc();
    mem_ready = 0;
    chk("wd_noready", {30'h0, mem_wr, ext_ready}, 32'h0);
    cyc();
    chk("wd_idle", {31'h0, ext_ready}, 32'h0);
    xfer("after_wd", 32'h1A1F_FFFF, 8'h99, 1'b0, 2, 8'h00);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: a = {12'h1A1, 3'b000, 17'($urandom)};
        1: a = {12'h1A1, 3'($urandom_range(1, 7)), 17'($urandom)};
        2: begin
          a = $urandom;
          if (a[31:12] == 20'h0) a[12] = 1'b1;
        end
        default: a = {20'h0, 12'($urandom)};
      endcase
      xfer("rnd", a, 8'($urandom), 1'($urandom), $urandom_range(0, 6), 8'($urandom));
    end
    chk("rnd_no_err", {31'h0, bus_err}, 32'h0);

    // Target that never answers.
    do_reset();
    addr_phase(32'h0040_0000, 8'h00);
    ext_read = 1;
    cyc();
`ifdef EXTBUS_TIMEOUT_EN
    cyc(16);
    chk("to_ready", {31'h0, ext_ready}, 32'h1);
    chk("to_data", {24'h0, ext_ad_out}, 32'hFF);
    chk("to_err", {31'h0, bus_err}, 32'h1);
    chk("to_drop", {31'h0, mem_rd}, 32'h0);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (ext_ready) seen = 1'b1;
    end
    chk("hang_noready", {31'h0, seen}, 32'h0);
    chk("hang_req", {31'h0, mem_rd}, 32'h1);
`endif
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
